// File: rtl/gpr_wb_pkg.sv
// Shared encodings and widths for the GPR writeback controller.
// Write enables are active-low and the reset is active-low.
package gpr_wb_pkg;

   localparam logic ENABLE_      = 1'b0;
   localparam logic DISABLE_     = 1'b1;
   localparam logic RESET_ENABLE = 1'b0;
   localparam int   REG_NUM      = 32;
   localparam int   REG_ADDR_W   = 5;
   localparam int   WORD_DATA_W  = 32;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_MEM  = 2'd1,
      SEL_EX   = 2'd2
   } wb_sel_e;

   function automatic logic [REG_NUM-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [REG_NUM-1:0] mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Circular buffer of pending EX results (address + data) with explicit count
// and flush. Per-entry valid/address are exported so the top can build busy.
module gpr_wb_fifo
   import gpr_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_ADDR_W,
   parameter int DW    = WORD_DATA_W,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [AW-1:0]     push_addr_i,
   input  logic [DW-1:0]     push_data_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [AW-1:0]     head_addr_o,
   output logic [DW-1:0]     head_data_o,
   output logic [CW-1:0]     cnt_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [DEPTH-1:0]  entry_valid_o,
   output logic [DEPTH*AW-1:0] entry_addr_o
);

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         // A push in the flush cycle is dropped along with the buffered entries.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         cnt_d = cnt_q + {{(CW-1){1'b0}}, push_i} - {{(CW-1){1'b0}}, pop_i};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (reset == RESET_ENABLE) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         addr_mem[wr_ptr_q] <= push_addr_i;
         data_mem[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_addr_o = addr_mem[rd_ptr_q];
   assign head_data_o = data_mem[rd_ptr_q];
   assign cnt_o       = cnt_q;
   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == CW'(DEPTH));

   // Slot gi is live when its distance from the read pointer is below the count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] offset;
      assign offset                       = PW'(gi) - rd_ptr_q;
      assign entry_valid_o[gi]            = ({1'b0, offset} < cnt_q);
      assign entry_addr_o[gi*AW +: AW]    = addr_mem[gi];
   end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR writeback controller: arbitrates load returns (priority) against
// buffered EX results onto a registered write port and exports busy.
module gpr_wb_ctrl
   import gpr_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_ADDR_W,
   parameter int DW    = WORD_DATA_W,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic [AW-1:0]      ex_addr,
   input  logic [DW-1:0]      ex_data,
   input  logic               mem_valid,
   input  logic [AW-1:0]      mem_addr,
   input  logic [DW-1:0]      mem_data,
   input  logic               flush,
   output logic               gpr_we_,
   output logic [AW-1:0]      gpr_wr_addr,
   output logic [DW-1:0]      gpr_wr_data,
   output logic [REG_NUM-1:0] busy,
   output logic [CW-1:0]      fifo_cnt,
   output logic               idle
);

   logic                we_q, we_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [DW-1:0]       data_q, data_d;

   wb_sel_e             sel;
   logic                push;
   logic                pop;
   logic [AW-1:0]       head_addr;
   logic [DW-1:0]       head_data;
   logic                fifo_empty;
   logic                fifo_full;
   logic [DEPTH-1:0]    entry_valid;
   logic [DEPTH*AW-1:0] entry_addr;
   logic [REG_NUM-1:0]  busy_mask;

   assign ex_ready = !fifo_full;
   assign push     = ex_valid && ex_ready && !flush;
   assign pop      = (sel == SEL_EX);

   gpr_wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push_i        (push),
      .push_addr_i   (ex_addr),
      .push_data_i   (ex_data),
      .pop_i         (pop),
      .flush_i       (flush),
      .head_addr_o   (head_addr),
      .head_data_o   (head_data),
      .cnt_o         (fifo_cnt),
      .empty_o       (fifo_empty),
      .full_o        (fifo_full),
      .entry_valid_o (entry_valid),
      .entry_addr_o  (entry_addr)
   );

   // Load returns cannot stall, so they always win; the FIFO head waits.
   always_comb begin
      sel = SEL_NONE;
      if (mem_valid)        sel = SEL_MEM;
      else if (!fifo_empty) sel = SEL_EX;
   end

   always_comb begin
      we_d   = DISABLE_;
      addr_d = addr_q;
      data_d = data_q;
      case (sel)
         SEL_MEM: begin
            we_d   = ENABLE_;
            addr_d = mem_addr;
            data_d = mem_data;
         end
         SEL_EX: begin
            we_d   = ENABLE_;
            addr_d = head_addr;
            data_d = head_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (reset == RESET_ENABLE) begin
         we_q   <= DISABLE_;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   // Pending destinations: live FIFO entries plus the write on the port now.
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) busy_mask |= reg_onehot(entry_addr[i*AW +: AW]);
      end
      if (we_q == ENABLE_) busy_mask |= reg_onehot(addr_q);
   end

   assign gpr_we_     = we_q;
   assign gpr_wr_addr = addr_q;
   assign gpr_wr_data = data_q;
   assign busy        = busy_mask;
   assign idle        = fifo_empty && (we_q == DISABLE_);

endmodule

// File: doc/gpr_wb_ctrl.md
Name: gpr_wb_ctrl

Overview:
Writeback controller that drives the single GPR write port (we_/wr_addr/wr_data) on behalf of two result producers: the EX pipeline and the memory load-return path. EX results are buffered in a small FIFO with a valid/ready handshake. Load returns cannot stall, so they take the port with priority. The block also exports a pending-write scoreboard that decode uses for RAW stall decisions.

Parameters:
DEPTH, 4, EX result FIFO depth (power of 2, >=2)
AW, 5, register address width (32 GPRs)
DW, 32, register data width (WORD_DATA_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
ex_valid  in  1  EX result valid
ex_ready  out  1  EX result accepted this cycle when ex_valid&ex_ready
ex_addr  in  AW  EX destination register
ex_data  in  DW  EX result
mem_valid  in  1  load-return result valid; always accepted, no ready
mem_addr  in  AW  load destination register
mem_data  in  DW  load data
flush  in  1  synchronous pipeline flush; discards buffered EX results
gpr_we_  out  1  GPR write enable, active-low (ENABLE_ = 0)
gpr_wr_addr  out  AW  GPR write address
gpr_wr_data  out  DW  GPR write data
busy  out  32  bit r set while a write to GPR r is pending in the FIFO or the output register
fifo_cnt  out  log2(DEPTH)+1  FIFO occupancy
idle  out  1  FIFO empty and gpr_we_ deasserted

Behaviour:
- Reset (reset==0, async): FIFO pointers and count = 0; gpr_we_ = 1; gpr_wr_addr = 0; gpr_wr_data = 0; busy = 0; ex_ready = 1; idle = 1.
- FIFO: circular buffer, rd/wr pointers wrap modulo DEPTH. Count is tracked explicitly, width log2(DEPTH)+1.
- ex_ready = (count != DEPTH), decoded from registered state only. There is no same-cycle pass-through when full, even if a dequeue happens in that cycle.
- Enqueue on the edge when ex_valid & ex_ready & !flush.
- Port arbitration is evaluated each cycle from current state:
  - If mem_valid: select MEM. The FIFO head is held.
  - Else if FIFO is not empty: select the head and dequeue it on this edge.
  - Else: no write.
- Write port outputs are registered. The selected request appears on gpr_we_/gpr_wr_addr/gpr_wr_data in the following cycle for exactly one cycle. With nothing selected, gpr_we_ = 1 and addr/data hold their previous values.
- Latency:
  - MEM: mem_valid in cycle N gives gpr_we_ = 0 in cycle N+1.
  - EX into an empty FIFO with no MEM traffic: accepted in cycle N, at head in N+1, written in N+2.
- Ordering: EX results are written in acceptance order. No reordering across sources; producers guarantee that MEM and EX never target the same register while both are pending.
- MEM back-to-back every cycle: EX is starved and the FIFO fills. ex_ready drops at count == DEPTH. No data is lost.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- flush: on the edge with flush = 1, pointers and count reset to 0 and any same-cycle enqueue is dropped. A head that was selected in that same cycle is still written, because it is already committed to the output register. A MEM write in flight is unaffected. busy clears its FIFO-derived bits the next cycle.
- busy: OR over valid FIFO entries of onehot(addr), plus onehot(gpr_wr_addr) when gpr_we_ = 0. It is combinational from registered state and includes r0.
- Reset asserted mid-operation: all state clears immediately and the pending write is lost. gpr_we_ goes to 1 asynchronously.

Decomposition:
- Shared package/header: ENABLE_/DISABLE_ encodings, REG_NUM, REG_ADDR_W, WORD_DATA_W, RESET_ENABLE.
- One sub-module: gpr_wb_fifo (parameterised DEPTH/width storage plus pointers/count, with flush). Arbitration, the output register and busy stay in the top.

Test Plan:
1. Reset low for 3 cycles, then high -> gpr_we_=1, busy=0, ex_ready=1, idle=1, fifo_cnt=0.
2. Single EX (addr=5, data=0xDEADBEEF) in cycle 0 -> gpr_we_=0, addr=5, data=0xDEADBEEF in cycle 2 only. busy[5]=1 during cycles 1-2, 0 in cycle 3.
3. mem_valid held 6 cycles while EX offers addrs 1..6 -> fifo_cnt reaches 4 and ex_ready=0 while full. After MEM stops, EX writes 1,2,3,4 then 5,6 appear in order on consecutive cycles, with no loss.
4. MEM (addr=9, 0x11) and EX (addr=3, 0x22) in the same cycle with the FIFO empty -> cycle 1 writes r9=0x11, cycle 2 writes r3=0x22.
5. FIFO holding 3 entries plus flush=1 for one cycle -> fifo_cnt=0 next cycle and the remaining entries are never written. The entry dequeued in the flush cycle is written.
6. Reset asserted while gpr_we_=0 -> gpr_we_=1 immediately (asynchronously), with no further writes after reset deasserts.
